// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard/stall unit: register-index width default,
// bubble encoding, FSM state encoding and the RegWrite normalisation helper.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  // A bubble carries no write, no load and destination x0.
  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMREAD  = 1'b0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } hsu_state_e;

  // Writes to x0 are dropped at the ID/EX boundary so later stages never see
  // a live write to x0 and the load-use compare can ignore rd==0.
  function automatic logic norm_regwrite(input logic regwrite, input logic rd_is_zero);
    return regwrite & ~rd_is_zero;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_pipe_ctrl_reg.sv
// One pipeline stage of destination/control info {RegWrite, MemRead, rd}.
// Ports:
//   clk, reset        clock, async active-low reset (clears to bubble)
//   hold              keep current contents (highest priority)
//   bubble            load a bubble instead of the incoming fields
//   regwrite_in/memread_in/rd_in    fields from the previous stage
//   regwrite_out/memread_out/rd_out registered fields
module pipe_ctrl_reg
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  bubble,
  input  logic                  regwrite_in,
  input  logic                  memread_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  regwrite_out,
  output logic                  memread_out,
  output logic [REG_ADDR_W-1:0] rd_out
);

  logic                  regwrite_q, regwrite_d;
  logic                  memread_q, memread_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  always_comb begin
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    rd_d       = rd_q;
    if (!hold) begin
      if (bubble) begin
        regwrite_d = BUBBLE_REGWRITE;
        memread_d  = BUBBLE_MEMREAD;
        rd_d       = '0;
      end else begin
        regwrite_d = regwrite_in;
        memread_d  = memread_in;
        rd_d       = rd_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_q <= BUBBLE_REGWRITE;
      memread_q  <= BUBBLE_MEMREAD;
      rd_q       <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      rd_q       <= rd_d;
    end
  end

  assign regwrite_out = regwrite_q;
  assign memread_out  = memread_q;
  assign rd_out       = rd_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard/stall unit: carries destination info ID->EX->MEM->WB for the
// forwarding unit and resolves load-use stalls, taken-branch flushes and
// memory-wait freezes. Keeps a saturating count of stalled/frozen cycles.
// Ports:
//   clk, reset                      clock, async active-low reset
//   valid_ID, RegWrite_ID, MemRead_ID, rd_ID, rs1_ID, rs2_ID   ID instruction
//   branch_taken_EX                 taken branch resolved in EX
//   mem_ready                       load data returns this cycle
//   stall_IF, stall_ID, flush_ID    front-end control
//   RegWrite_/MemRead_/rd_ EX, MEM  stage fields; RegWrite_WB, rd_WB
//   mem_wait                        FSM in WAIT
//   stall_cycles                    saturating stall/freeze counter
//
// state | meaning
// ------+--------------------------------------------------
// RUN   | pipeline advancing normally
// WAIT  | a load in MEM is waiting for memory (informational)
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_ID,
  input  logic                  RegWrite_ID,
  input  logic                  MemRead_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  branch_taken_EX,
  input  logic                  mem_ready,
  output logic                  stall_IF,
  output logic                  stall_ID,
  output logic                  flush_ID,
  output logic                  RegWrite_EX,
  output logic                  MemRead_EX,
  output logic [REG_ADDR_W-1:0] rd_EX,
  output logic                  RegWrite_MEM,
  output logic                  MemRead_MEM,
  output logic [REG_ADDR_W-1:0] rd_MEM,
  output logic                  RegWrite_WB,
  output logic [REG_ADDR_W-1:0] rd_WB,
  output logic                  mem_wait,
  output logic [CNT_W-1:0]      stall_cycles
);

  hsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use, freeze, lu_stall, stall_event;
  logic             memread_wb_unused;

  assign load_use = MemRead_EX & RegWrite_EX & valid_ID &
                    ((rd_EX == rs1_ID) | (rd_EX == rs2_ID));
  assign freeze   = MemRead_MEM & ~mem_ready;
  // A taken branch kills the dependent instruction, so its load-use is moot.
  assign lu_stall    = load_use & ~branch_taken_EX & ~freeze;
  assign stall_event = freeze | lu_stall;

  assign stall_IF = stall_event;
  assign stall_ID = stall_event;
  // Gated by reset so a stray branch input cannot flush during reset.
  assign flush_ID = reset & ~freeze & branch_taken_EX;

  pipe_ctrl_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
    .clk          (clk),
    .reset        (reset),
    .hold         (freeze),
    .bubble       (branch_taken_EX | lu_stall | ~valid_ID),
    .regwrite_in  (norm_regwrite(RegWrite_ID, rd_ID == '0)),
    .memread_in   (MemRead_ID),
    .rd_in        (rd_ID),
    .regwrite_out (RegWrite_EX),
    .memread_out  (MemRead_EX),
    .rd_out       (rd_EX)
  );

  pipe_ctrl_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
    .clk          (clk),
    .reset        (reset),
    .hold         (freeze),
    .bubble       (1'b0),
    .regwrite_in  (RegWrite_EX),
    .memread_in   (MemRead_EX),
    .rd_in        (rd_EX),
    .regwrite_out (RegWrite_MEM),
    .memread_out  (MemRead_MEM),
    .rd_out       (rd_MEM)
  );

  // WB takes a bubble while MEM is frozen so the load is not written twice.
  pipe_ctrl_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
    .clk          (clk),
    .reset        (reset),
    .hold         (1'b0),
    .bubble       (freeze),
    .regwrite_in  (RegWrite_MEM),
    .memread_in   (MemRead_MEM),
    .rd_in        (rd_MEM),
    .regwrite_out (RegWrite_WB),
    .memread_out  (memread_wb_unused),
    .rd_out       (rd_WB)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:  if (freeze)    state_d = ST_WAIT;
      ST_WAIT: if (mem_ready) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_event && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wait     = (state_q == ST_WAIT);
  assign stall_cycles = cnt_q;

endmodule
